// File: rtl/winograd_pkg.sv
// winograd_pkg: shared widths, tile sizes and FSM state type for the Winograd filter transform
package winograd_pkg;
    localparam int G_W    = 8;
    localparam int GG_W   = 16;
    localparam int OUT_W  = 26;
    localparam int TILE_M = 4;
    localparam int TILE_K = 3;
    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} xform_state_t;
endpackage

// File: rtl/dot3_signed.sv
// dot3_signed: combinational 3-term signed dot product, sign-extended to OUT_W
module dot3_signed import winograd_pkg::*; #(
    parameter int G_W   = winograd_pkg::G_W,
    parameter int GG_W  = winograd_pkg::GG_W,
    parameter int OUT_W = winograd_pkg::OUT_W
) (
    input  logic [0:TILE_K-1][G_W-1:0]  g,
    input  logic [0:TILE_K-1][GG_W-1:0] gg,
    output logic [OUT_W-1:0]            dot
);
    logic signed [G_W+GG_W-1:0] p [TILE_K];
    always_comb begin
        for (int k = 0; k < TILE_K; k++)
            p[k] = (G_W+GG_W)'($signed(g[k])) * (G_W+GG_W)'($signed(gg[k]));
    end
    assign dot = OUT_W'(p[0]) + OUT_W'(p[1]) + OUT_W'(p[2]);
endmodule

// File: rtl/filter_xform_gt_stage.sv
// filter_xform_gt_stage: U = (G*g) * G^T, one output row per cycle, valid/ready on both sides
module filter_xform_gt_stage import winograd_pkg::*; #(
    parameter int G_W   = winograd_pkg::G_W,
    parameter int GG_W  = winograd_pkg::GG_W,
    parameter int OUT_W = winograd_pkg::OUT_W
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [0:TILE_M-1][0:TILE_K-1][G_W-1:0]  transformation_mtx,
    input  logic [0:TILE_M-1][0:TILE_K-1][GG_W-1:0] gg_mtx,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [0:TILE_M-1][0:TILE_M-1][OUT_W-1:0] result_mtx
);
    xform_state_t state, state_nxt;
    logic [1:0] row_cnt;
    logic [0:TILE_M-1][0:TILE_K-1][G_W-1:0]  g_q;
    logic [0:TILE_M-1][0:TILE_K-1][GG_W-1:0] gg_q;
    logic [0:TILE_M-1][OUT_W-1:0]            row_res;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? COMPUTE : IDLE;
            COMPUTE: state_nxt = (row_cnt == 2'(TILE_M-1)) ? DONE : COMPUTE;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // row_cnt wraps 3 -> 0 on the last COMPUTE edge, ready for the next job
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt    <= '0;
            g_q        <= '0;
            gg_q       <= '0;
            result_mtx <= '0;
        end else if (in_ready && in_valid) begin
            row_cnt <= '0;
            g_q     <= transformation_mtx;
            gg_q    <= gg_mtx;
        end else if (state == COMPUTE) begin
            result_mtx[row_cnt] <= row_res;
            row_cnt             <= row_cnt + 2'd1;
        end
    end

    genvar c;
    generate
        for (c = 0; c < TILE_M; c++) begin : g_col
            dot3_signed #(.G_W(G_W), .GG_W(GG_W), .OUT_W(OUT_W)) u_dot (
                .g   (g_q[c]),
                .gg  (gg_q[row_cnt]),
                .dot (row_res[c])
            );
        end
    endgenerate
endmodule
